debug_program_loader: RTL and testbench
=======================================

# debug_program_loader

Synthesizable successor to the bench-only program loader for the MIPS debug unit. It pulls instruction words from a word source and sends a `StartSignal` byte, then each word as LEN/8 bytes least-significant byte first, over a byte-wide UART transmit handshake. When it detects the halt instruction it sends the selected run-mode command. In step mode it then forwards operator step requests as `StepSignal` bytes. It sits between program storage (ROM or host FIFO) and the UART TX feeding the debug unit's receive path.

## Interface
- `LEN`, 32: instruction width in bits; must be a multiple of 8, range 8..64.
- `MAX_WORDS`, 1024: word limit; loading this many words without seeing a halt is an error.
- `TIMEOUT_CYCLES`, 2000000: watchdog limit on waiting for `tx_done`; used only when the watchdog is compiled in.
- `CLK100MHZ` in 1: the single clock; everything is sampled on the rising edge.
- `SWITCH_RESET` in 1: asynchronous reset, active-low.
- `start` in 1: one-cycle pulse; begins a load; ignored unless in IDLE.
- `step_mode` in 1: sampled at `start`; 0 selects continuous run, 1 selects step-by-step.
- `step_req` in 1: one-cycle pulse; requests one `StepSignal`; accepted only in STEP_WAIT.
- `abort` in 1: synchronous return to IDLE from any state.
- `word_data` in LEN: instruction word from the source.
- `word_valid` in 1: source has a word available.
- `word_ready` out 1: word accepted this cycle.
- `tx_data` out 8: byte presented to the UART TX.
- `tx_start` out 1: transmit request.
- `tx_done` in 1: one-cycle pulse from the TX when the byte has been sent.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `done` out 1: high in DONE.
- `error` out 1: high in ERROR.
- `words_sent` out clog2(MAX_WORDS+1): number of complete words sent in the current load.

## Operation
- Command bytes: START=0x01, CONTINUOUS=0x02, STEP_BY_STEP=0x03, STEP=0x06.
- A word is a halt when `word[LEN-1:LEN-6]` are all ones.
- State machine:
  - IDLE →`start`→ SEND_START.
  - SEND_START →`tx_done`→ FETCH.
  - FETCH: waits for `word_valid`, latches the word, pulses `word_ready` for one cycle → SEND_WORD with byte index 0.
  - SEND_WORD: sends bytes 0..LEN/8-1. After the last byte: increment `words_sent`; then:
    - if the word is a halt → SEND_MODE;
    - else if `words_sent` has reached MAX_WORDS → ERROR;
    - else → FETCH.
  - SEND_MODE: sends CONTINUOUS or STEP_BY_STEP; then → DONE if continuous, → STEP_WAIT if step mode.
  - STEP_WAIT →`step_req`→ SEND_STEP →`tx_done`→ STEP_WAIT.
  - DONE and ERROR → IDLE on `start` or `abort`.
- `abort` overrides every other transition. It drops `tx_start` in the same clock edge.
- Byte selection: `tx_data = word[8*i+7:8*i]`, where `i` is the byte index.
- Counter width: `words_sent` saturates and never wraps. It clears to 0 when `start` is accepted.

## Timing
- Reset values: state=IDLE, `tx_start`=0, `tx_data`=0x00, `word_ready`=0, `busy`=0, `done`=0, `error`=0, `words_sent`=0.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). No partial byte is re-sent after reset is released.
- `tx_start` rises the cycle after a byte-send state is entered. It then stays high with `tx_data` stable until `tx_done` is sampled high.
- In the cycle after `tx_done` is sampled, `tx_start` is 0. Every byte is therefore separated by at least one low cycle.
- `tx_done` arriving while `tx_start` is low is ignored.
- `word_ready` is a one-cycle pulse, coincident with the `word_valid`=1 cycle in which FETCH accepts the word.
- Latency, `start` pulse to first `tx_start`: 2 cycles.
- Latency, last `tx_done` of a word to `word_ready` of the next word: 2 cycles, given `word_valid` is already high.
- Simultaneous `step_req` and `abort`: `abort` wins.
- `step_req` outside STEP_WAIT is dropped, not queued.

## Configuration
- `DEBUG_LOADER_WATCHDOG_EN` defined:
  - A cycle counter runs while `tx_start`=1 and clears on `tx_done`.
  - If it reaches TIMEOUT_CYCLES, the block enters ERROR and drops `tx_start`.
- Not defined: no counter is built, and the block waits for `tx_done` indefinitely.

## Structure
- Shared package `debug_loader_pkg` holds:
  - the state enumeration;
  - the four command-byte constants;
  - the halt opcode constant 6'b111111.
- Sub-module `byte_serializer`: takes a LEN-bit word and runs the byte index and the `tx_start`/`tx_done` handshake. Its outputs are a `last_byte` flag and a one-cycle `word_sent` pulse.
- The command bytes reuse `byte_serializer` with a single-byte length flag.

## Test plan
- Continuous load, LEN=32, words 0x20010005 then 0xFC000000, `tx_done` returned 3 cycles after each `tx_start` → `tx_data` sequence 01,05,00,01,20,00,00,00,FC,02; then `done`=1 and `words_sent`=2.
- Step mode, same program, then 3 `step_req` pulses (one of them sent during SEND_MODE) → last mode byte is 03; then exactly two 06 bytes; `busy` stays 1.
- MAX_WORDS=4 with no halt in the program → 4 words sent (16 data bytes after 01); then `error`=1 and `tx_start`=0.
- `SWITCH_RESET` asserted during byte 2 of word 1 → all outputs at reset values within the same cycle. After release, `start` re-sends 01 first and `words_sent`=0.
- `abort` while `word_valid`=0 in FETCH → IDLE next cycle; no `word_ready` pulse.
- With `DEBUG_LOADER_WATCHDOG_EN` defined and TIMEOUT_CYCLES=100, `tx_done` never returned → `error`=1 exactly 100 cycles after `tx_start` rises.

Source files
------------

// File: rtl/debug_loader_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_loader_pkg: shared states, command bytes and helpers for the
// debug program loader.                                  Rev 1.0
// ------------------------------------------------------------------
package debug_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SEND_START = 4'd1,
    ST_FETCH      = 4'd2,
    ST_SEND_WORD  = 4'd3,
    ST_SEND_MODE  = 4'd4,
    ST_STEP_WAIT  = 4'd5,
    ST_SEND_STEP  = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERROR      = 4'd8
  } loader_state_t;

  localparam logic [7:0] c_CMD_START        = 8'h01;
  localparam logic [7:0] c_CMD_CONTINUOUS   = 8'h02;
  localparam logic [7:0] c_CMD_STEP_BY_STEP = 8'h03;
  localparam logic [7:0] c_CMD_STEP         = 8'h06;

  localparam logic [5:0] c_HALT_OPCODE = 6'b111111;

  function automatic logic is_halt_opcode(input logic [5:0] op);
    return op == c_HALT_OPCODE;
  endfunction

  function automatic logic is_send_state(input loader_state_t s);
    return (s == ST_SEND_START) || (s == ST_SEND_WORD) ||
           (s == ST_SEND_MODE)  || (s == ST_SEND_STEP);
  endfunction

  function automatic logic is_busy_state(input loader_state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_program_loader_if.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_program_loader_if: word-source and UART TX handshakes of the
// program loader. master = loader side.                  Rev 1.0
// ------------------------------------------------------------------
interface debug_program_loader_if #(
  parameter int LEN = 32
) ();
  logic [LEN-1:0] word_data;
  logic           word_valid;
  logic           word_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done;

  modport master (
    input  word_data, word_valid, tx_done,
    output word_ready, tx_data, tx_start
  );

  modport slave (
    output word_data, word_valid, tx_done,
    input  word_ready, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/byte_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// byte_serializer: sends a LEN-bit word (or its low byte only) LSB
// first over a tx_start/tx_done handshake.               Rev 1.0
// ------------------------------------------------------------------
module byte_serializer #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           single,
  input  logic [LEN-1:0] data,
  input  logic           flush,
  input  logic           tx_done,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  output logic           last_byte,
  output logic           word_sent
);

  localparam logic [2:0] c_LAST_IDX = 3'(LEN / 8 - 1);

  logic [LEN-1:0] r_shift;
  logic [2:0]     r_idx;
  logic           r_single;
  logic           r_pending;
  logic           r_tx_start;
  logic           r_word_sent;

  assign last_byte = r_single || (r_idx == c_LAST_IDX);
  assign tx_data   = r_shift[7:0];
  assign tx_start  = r_tx_start;
  assign word_sent = r_word_sent;

  // r_pending forces one low cycle on tx_start between consecutive bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_single    <= 1'b0;
      r_pending   <= 1'b0;
      r_tx_start  <= 1'b0;
      r_word_sent <= 1'b0;
    end else begin
      r_word_sent <= 1'b0;
      if (flush) begin
        r_tx_start <= 1'b0;
        r_pending  <= 1'b0;
      end else if (load) begin
        r_shift    <= data;
        r_idx      <= '0;
        r_single   <= single;
        r_tx_start <= 1'b1;
        r_pending  <= 1'b0;
      end else if (r_tx_start && tx_done) begin
        r_tx_start <= 1'b0;
        if (last_byte) begin
          r_word_sent <= 1'b1;
        end else begin
          r_shift   <= r_shift >> 8;
          r_idx     <= r_idx + 3'd1;
          r_pending <= 1'b1;
        end
      end else if (r_pending) begin
        r_tx_start <= 1'b1;
        r_pending  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_program_loader.sv
`default_nettype none
// ------------------------------------------------------------------
// debug_program_loader: streams program words and debug commands to a
// UART TX. Optional tx_done watchdog: DEBUG_LOADER_WATCHDOG_EN. Rev 1.0
// ------------------------------------------------------------------
module debug_program_loader
  import debug_loader_pkg::*;
#(
  parameter int LEN            = 32,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                               CLK100MHZ,
  input  logic                               SWITCH_RESET,
  input  logic                               start,
  input  logic                               step_mode,
  input  logic                               step_req,
  input  logic                               abort,
  debug_program_loader_if.master             bus,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [$clog2(MAX_WORDS+1)-1:0]     words_sent
);

  localparam int                c_CNT_W    = $clog2(MAX_WORDS + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_WORDS);
  localparam logic [c_CNT_W-1:0] c_MAX_LAST = c_CNT_W'(MAX_WORDS - 1);

  loader_state_t        r_state;
  loader_state_t        w_nx;
  logic [LEN-1:0]       r_word;
  logic                 r_step_mode;
  logic                 r_load;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic [c_CNT_W-1:0]   r_words_sent;

  logic [LEN-1:0]       w_ser_data;
  logic                 w_single;
  logic                 w_flush;
  logic                 w_tx_start;
  logic                 w_last_byte;
  logic                 w_word_sent;
  logic                 w_word_done;
  logic                 w_halt;
  logic                 w_timeout;

  assign w_halt      = is_halt_opcode(r_word[LEN-1 -: 6]);
  assign w_single    = (r_state != ST_SEND_WORD);
  assign w_word_done = w_word_sent && w_last_byte;
  assign w_flush     = abort || w_timeout;

  assign bus.word_ready = (r_state == ST_FETCH) && bus.word_valid && !abort;
  assign bus.tx_start   = w_tx_start;

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign words_sent = r_words_sent;

  always_comb begin
    w_ser_data = '0;
    case (r_state)
      ST_SEND_WORD:  w_ser_data      = r_word;
      ST_SEND_START: w_ser_data[7:0] = c_CMD_START;
      ST_SEND_MODE:  w_ser_data[7:0] = r_step_mode ? c_CMD_STEP_BY_STEP : c_CMD_CONTINUOUS;
      ST_SEND_STEP:  w_ser_data[7:0] = c_CMD_STEP;
      default:       w_ser_data      = '0;
    endcase
  end

`ifdef DEBUG_LOADER_WATCHDOG_EN
  localparam int               c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

  logic [c_WD_W-1:0] r_wd_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle of tx_start without tx_done
  assign w_timeout = w_tx_start && !bus.tx_done && (r_wd_cnt == c_WD_LAST);

  always_ff @(posedge CLK100MHZ or negedge SWITCH_RESET) begin
    if (!SWITCH_RESET) begin
      r_wd_cnt <= '0;
    end else if (!w_tx_start || bus.tx_done || w_timeout || abort) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_nx = r_state;
    case (r_state)
      ST_IDLE:       if (start) w_nx = ST_SEND_START;
      ST_SEND_START: if (w_word_done) w_nx = ST_FETCH;
      ST_FETCH:      if (bus.word_valid) w_nx = ST_SEND_WORD;
      ST_SEND_WORD: begin
        if (w_word_done) begin
          if (w_halt)                          w_nx = ST_SEND_MODE;
          else if (r_words_sent >= c_MAX_LAST) w_nx = ST_ERROR;
          else                                 w_nx = ST_FETCH;
        end
      end
      ST_SEND_MODE:  if (w_word_done) w_nx = r_step_mode ? ST_STEP_WAIT : ST_DONE;
      ST_STEP_WAIT:  if (step_req) w_nx = ST_SEND_STEP;
      ST_SEND_STEP:  if (w_word_done) w_nx = ST_STEP_WAIT;
      ST_DONE,
      ST_ERROR:      if (start) w_nx = ST_IDLE;
      default:       w_nx = ST_IDLE;
    endcase
    if (w_timeout) w_nx = ST_ERROR;
    if (abort)     w_nx = ST_IDLE;
  end

  // Status flags and the serializer load strobe are decoded from the next state
  always_ff @(posedge CLK100MHZ or negedge SWITCH_RESET) begin
    if (!SWITCH_RESET) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_step_mode  <= 1'b0;
      r_load       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_words_sent <= '0;
    end else begin
      r_state <= w_nx;
      r_load  <= (w_nx != r_state) && is_send_state(w_nx);
      r_busy  <= is_busy_state(w_nx);
      r_done  <= (w_nx == ST_DONE);
      r_error <= (w_nx == ST_ERROR);
      if ((r_state == ST_IDLE) && (w_nx == ST_SEND_START)) begin
        r_words_sent <= '0;
        r_step_mode  <= step_mode;
      end
      if (bus.word_ready) r_word <= bus.word_data;
      if ((r_state == ST_SEND_WORD) && w_word_done && (r_words_sent != c_MAX_CNT))
        r_words_sent <= r_words_sent + 1'b1;
    end
  end

  byte_serializer #(
    .LEN (LEN)
  ) u_byte_serializer (
    .clk       (CLK100MHZ),
    .rst_n     (SWITCH_RESET),
    .load      (r_load),
    .single    (w_single),
    .data      (w_ser_data),
    .flush     (w_flush),
    .tx_done   (bus.tx_done),
    .tx_data   (bus.tx_data),
    .tx_start  (w_tx_start),
    .last_byte (w_last_byte),
    .word_sent (w_word_sent)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_debug_program_loader: scoreboard bench; a TX responder returns
// tx_done 3 cycles after each tx_start and checks bytes.  Rev 1.0
// ------------------------------------------------------------------
module tb_debug_program_loader;

  localparam int LEN            = 32;
  localparam int MAX_WORDS      = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CNT_W          = $clog2(MAX_WORDS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic step_mode = 1'b0;
  logic step_req = 1'b0;
  logic abort = 1'b0;
  logic busy, done, error;
  logic [CNT_W-1:0] words_sent;

  debug_program_loader_if #(.LEN(LEN)) bus ();

  debug_program_loader #(
    .LEN            (LEN),
    .MAX_WORDS      (MAX_WORDS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLK100MHZ    (clk),
    .SWITCH_RESET (rst_n),
    .start        (start),
    .step_mode    (step_mode),
    .step_req     (step_req),
    .abort        (abort),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_sent   (words_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bytes_seen = 0;
  int ready_cnt = 0;
  bit resp_en = 1'b1;
  bit sb_en = 1'b1;
  logic [7:0]     exp_q[$];
  logic [LEN-1:0] src_q[$];
  int             done_cyc[$];
  int             rdy_cyc[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // word source: presents the queue head, pops when the DUT accepts
  initial begin
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    forever begin
      @(negedge clk);
      bus.word_valid = (src_q.size() > 0);
      bus.word_data  = (src_q.size() > 0) ? src_q[0] : '0;
      #1;
      if (bus.word_ready === 1'b1) begin
        ready_cnt++;
        rdy_cyc.push_back(cyc);
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
    end
  end

  // UART TX model and byte scoreboard
  initial begin
    logic [7:0] e;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && bus.tx_start === 1'b1) begin
        bytes_seen++;
        if (sb_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_byte: got %02h, required no byte", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.tx_data !== e) begin
              errors++;
              $display("FAIL tx_byte: got %02h, required %02h", bus.tx_data, e);
            end
          end
        end
        repeat (3) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        done_cyc.push_back(cyc);
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
        checks++;
        if (bus.tx_start !== 1'b0) begin
          errors++;
          $display("FAIL tx_gap: tx_start got %b after tx_done, required 0", bus.tx_start);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic push_word(input logic [LEN-1:0] w);
    src_q.push_back(w);
    for (int b = 0; b < LEN / 8; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || error === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bytes_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({bus.tx_start, bus.tx_data, bus.word_ready, busy, done, error} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b data=%02h ready=%b busy=%b done=%b error=%b, required all 0",
               bus.tx_start, bus.tx_data, bus.word_ready, busy, done, error);
    end
    checks++;
    if (words_sent !== '0) begin
      errors++;
      $display("FAIL reset_words_sent: got %0d, required 0", words_sent);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_continuous();
    bit ok;
    exp_q.delete(); src_q.delete(); done_cyc.delete(); rdy_cyc.delete();
    step_mode = 1'b0;
    exp_q.push_back(8'h01);
    push_word(32'h2001_0005);
    push_word(32'hFC00_0000);
    exp_q.push_back(8'h02);
    pulse_start();
    checks++;
    if (bus.tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency_1: tx_start=%b busy=%b, required 0 and 1", bus.tx_start, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.tx_start !== 1'b1) begin
      errors++;
      $display("FAIL start_latency_2: tx_start=%b, required 1", bus.tx_start);
    end
    wait_end(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cont_timeout: done=%b error=%b, required done=1", done, error);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || words_sent !== 3'(2)) begin
      errors++;
      $display("FAIL cont_final: done=%b busy=%b error=%b words=%0d, required 1 0 0 2",
               done, busy, error, words_sent);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_bytes_left: got %0d unsent, required 0", exp_q.size());
    end
    checks++;
    if (done_cyc.size() < 5 || rdy_cyc.size() < 2) begin
      errors++;
      $display("FAIL word_latency: got %0d tx_done / %0d ready events, required 5 / 2",
               done_cyc.size(), rdy_cyc.size());
    end else if (rdy_cyc[1] - done_cyc[4] != 2) begin
      errors++;
      $display("FAIL word_latency: got %0d cycles, required 2", rdy_cyc[1] - done_cyc[4]);
    end
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_to_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_step_mode();
    bit ok;
    int b0;
    exp_q.delete(); src_q.delete();
    b0 = bytes_seen;
    exp_q.push_back(8'h01);
    push_word(32'h2001_0005);
    push_word(32'hFC00_0000);
    exp_q.push_back(8'h03);
    step_mode = 1'b1;
    pulse_start();
    step_mode = 1'b0;
    wait_bytes(b0 + 10, 500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL step_mode_byte: got %0d bytes, required %0d", bytes_seen - b0, 10);
    end
    step_req = 1'b1;
    @(posedge clk); #1 step_req = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL step_wait: busy=%b done=%b left=%0d, required 1 0 0", busy, done, exp_q.size());
    end
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h06);
    step_req = 1'b1;
    @(posedge clk); #1 step_req = 1'b0;
    repeat (12) @(posedge clk); #1;
    step_req = 1'b1;
    @(posedge clk); #1 step_req = 1'b0;
    repeat (12) @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || bytes_seen - b0 != 12) begin
      errors++;
      $display("FAIL step_bytes: got %0d bytes with %0d unsent, required 12 and 0",
               bytes_seen - b0, exp_q.size());
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || words_sent !== 3'(2)) begin
      errors++;
      $display("FAIL step_status: busy=%b done=%b words=%0d, required 1 0 2", busy, done, words_sent);
    end
    pulse_abort();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL step_abort: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_max_words();
    bit ok;
    int r0;
    exp_q.delete(); src_q.delete();
    r0 = ready_cnt;
    exp_q.push_back(8'h01);
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    push_word(32'h99AA_BBCC);
    push_word(32'h0DEE_F001);
    src_q.push_back(32'h1234_5678);
    pulse_start();
    wait_end(800, ok);
    checks++;
    if (!ok || error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL max_words_error: error=%b done=%b busy=%b, required 1 0 0", error, done, busy);
    end
    checks++;
    if (bus.tx_start !== 1'b0 || words_sent !== 3'(4)) begin
      errors++;
      $display("FAIL max_words_final: tx_start=%b words=%0d, required 0 4", bus.tx_start, words_sent);
    end
    checks++;
    if (exp_q.size() != 0 || ready_cnt - r0 != 4) begin
      errors++;
      $display("FAIL max_words_count: unsent=%0d accepted=%0d, required 0 4", exp_q.size(), ready_cnt - r0);
    end
    pulse_abort();
    src_q.delete();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_abort: error=%b, required 0", error);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid_transfer();
    bit ok;
    int b0;
    exp_q.delete(); src_q.delete();
    sb_en = 1'b0;
    b0 = bytes_seen;
    src_q.push_back(32'h0102_0304);
    src_q.push_back(32'h0A0B_0C0D);
    src_q.push_back(32'hFC00_0000);
    pulse_start();
    wait_bytes(b0 + 8, 500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_reach_byte: got %0d bytes, required 8", bytes_seen - b0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_start, bus.tx_data, bus.word_ready, busy, done, error} !== 12'h000 || words_sent !== '0) begin
      errors++;
      $display("FAIL async_reset: start=%b data=%02h ready=%b busy=%b done=%b error=%b words=%0d, required all 0",
               bus.tx_start, bus.tx_data, bus.word_ready, busy, done, error, words_sent);
    end
    repeat (6) @(posedge clk);
    src_q.delete(); exp_q.delete();
    #1 rst_n = 1'b1;
    sb_en = 1'b1;
    exp_q.push_back(8'h01);
    push_word(32'h2001_0005);
    push_word(32'hFC00_0000);
    exp_q.push_back(8'h02);
    pulse_start();
    checks++;
    if (words_sent !== '0) begin
      errors++;
      $display("FAIL rst_words_sent: got %0d, required 0", words_sent);
    end
    wait_end(500, ok);
    checks++;
    if (!ok || done !== 1'b1 || words_sent !== 3'(2) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_reload: done=%b words=%0d unsent=%0d, required 1 2 0", done, words_sent, exp_q.size());
    end
    pulse_start();
  endtask

  task automatic test_abort();
    bit ok;
    int b0;
    int r0;
    exp_q.delete(); src_q.delete();
    b0 = bytes_seen;
    exp_q.push_back(8'h01);
    pulse_start();
    wait_bytes(b0 + 1, 50, ok);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (!ok || busy !== 1'b1 || bus.word_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_fetch_pre: busy=%b ready=%b, required 1 0", busy, bus.word_ready);
    end
    r0 = ready_cnt;
    pulse_abort();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || ready_cnt != r0) begin
      errors++;
      $display("FAIL abort_in_fetch: busy=%b done=%b error=%b ready_pulses=%0d, required 0 0 0 0",
               busy, done, error, ready_cnt - r0);
    end
    src_q.push_back(32'h0000_0001);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (ready_cnt != r0) begin
      errors++;
      $display("FAIL abort_idle_fetch: ready_pulses=%0d, required 0", ready_cnt - r0);
    end
    src_q.delete();
    exp_q.push_back(8'h01);
    pulse_start();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++;
    if (bus.tx_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_drops_tx: tx_start=%b busy=%b, required 0 0", bus.tx_start, busy);
    end
    repeat (8) @(posedge clk); #1;
    checks++;
    if (bus.tx_start !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_resend: tx_start=%b unsent=%0d, required 0 0", bus.tx_start, exp_q.size());
    end
  endtask

  task automatic test_watchdog();
    int n;
    exp_q.delete(); src_q.delete();
    resp_en = 1'b0;
    pulse_start();
    @(posedge clk); #1;
`ifdef DEBUG_LOADER_WATCHDOG_EN
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      n++;
      if (error === 1'b1) break;
    end
    checks++;
    if (error !== 1'b1 || n != TIMEOUT_CYCLES) begin
      errors++;
      $display("FAIL watchdog: error=%b after %0d cycles, required 1 after %0d", error, n, TIMEOUT_CYCLES);
    end
    checks++;
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_tx: tx_start=%b, required 0", bus.tx_start);
    end
`else
    n = 150;
    repeat (n) @(posedge clk); #1;
    checks++;
    if (bus.tx_start !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL no_watchdog_hold: tx_start=%b error=%b busy=%b, required 1 0 1",
               bus.tx_start, error, busy);
    end
`endif
    pulse_abort();
    resp_en = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_step_mode();
    test_max_words();
    test_reset_mid_transfer();
    test_abort();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
